// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt/RTI sequencer: state encoding and the
// stack-control field layout that matches the ID/EX buffer.
// No ports; imported by the interface-using modules.
package interrupt_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DRAIN      = 3'd1,
      ST_PUSH_PC    = 3'd2,
      ST_PUSH_FLAGS = 3'd3,
      ST_VECTOR     = 3'd4,
      ST_POP_FLAGS  = 3'd5,
      ST_POP_PC     = 3'd6,
      ST_RTI_WAIT   = 3'd7
   } seq_state_t;

   // Bit positions of the stack-control fields inside the ID/EX buffer.
   localparam int CTL_SP          = 0;
   localparam int CTL_SPOP        = 1;
   localparam int CTL_MR          = 2;
   localparam int CTL_MW          = 3;
   localparam int CTL_STACK_PC    = 4;
   localparam int CTL_STACK_FLAGS = 5;
   localparam int CTL_W           = 6;

   typedef logic [CTL_W-1:0] stack_ctl_t;

   // Stack-control word injected into ID/EX for a given sequencer state.
   // Pushes pre-decrement SP (SPOP=0) and write memory; pops read memory.
   function automatic stack_ctl_t stack_ctl(seq_state_t s);
      stack_ctl_t c;
      c = '0;
      case (s)
         ST_PUSH_PC: begin
            c[CTL_SP]       = 1'b1;
            c[CTL_MW]       = 1'b1;
            c[CTL_STACK_PC] = 1'b1;
         end
         ST_PUSH_FLAGS: begin
            c[CTL_SP]          = 1'b1;
            c[CTL_MW]          = 1'b1;
            c[CTL_STACK_FLAGS] = 1'b1;
         end
         ST_POP_FLAGS: begin
            c[CTL_SP]          = 1'b1;
            c[CTL_SPOP]        = 1'b1;
            c[CTL_MR]          = 1'b1;
            c[CTL_STACK_FLAGS] = 1'b1;
         end
         ST_POP_PC: begin
            c[CTL_SP]       = 1'b1;
            c[CTL_SPOP]     = 1'b1;
            c[CTL_MR]       = 1'b1;
            c[CTL_STACK_PC] = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Bundle between the pipeline (decode/execute/fetch) and the interrupt sequencer.
// Ports: requests in (INT_Request, RTI_Decoded, Jump_In_Flight, Current_PC);
// controls out (Stall_Fetch, Flush_Decode, Inject_*, PC_Load*, Busy).
interface interrupt_sequencer_if;

   logic        INT_Request;
   logic        RTI_Decoded;
   logic        Jump_In_Flight;
   logic [31:0] Current_PC;

   logic        Stall_Fetch;
   logic        Flush_Decode;
   logic        Inject_Valid;
   logic        Inject_SP;
   logic        Inject_SPOP;
   logic        Inject_MR;
   logic        Inject_MW;
   logic        Inject_Stack_PC;
   logic        Inject_Stack_Flags;
   logic [31:0] Inject_PC;
   logic        PC_Load;
   logic [31:0] PC_Load_Value;
   logic        Busy;

   // Sequencer side: consumes requests, drives pipeline controls.
   modport master (
      input  INT_Request, RTI_Decoded, Jump_In_Flight, Current_PC,
      output Stall_Fetch, Flush_Decode, Inject_Valid, Inject_SP, Inject_SPOP,
             Inject_MR, Inject_MW, Inject_Stack_PC, Inject_Stack_Flags,
             Inject_PC, PC_Load, PC_Load_Value, Busy
   );

   // Pipeline side: raises requests, obeys controls.
   modport slave (
      output INT_Request, RTI_Decoded, Jump_In_Flight, Current_PC,
      input  Stall_Fetch, Flush_Decode, Inject_Valid, Inject_SP, Inject_SPOP,
             Inject_MR, Inject_MW, Inject_Stack_PC, Inject_Stack_Flags,
             Inject_PC, PC_Load, PC_Load_Value, Busy
   );

endinterface

// File: rtl/interrupt_sequencer_seq_down_counter.sv
// Loadable down-counter with zero flag, shared by the drain and RTI-wait phases.
// Latency: load/decrement take effect at the next clk; zero is registered-state derived.
// Ports: clk, rst_n, load, load_value, dec in; zero out. Saturates at 0.
module seq_down_counter #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   input  logic          dec,
   output logic          zero
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/interrupt_sequencer.sv
// Sequences stack pushes/pops into ID/EX for interrupt entry and RTI, then redirects/holds fetch.
// Latency: interrupt = 1 decision edge + DRAIN_CYCLES + 3 cycles; RTI = 2 + RTI_WAIT_CYCLES cycles.
// Ports: clk, rst_n, seq_bus (master modport). Moore outputs; fetch is stalled while the sequence owns ID/EX.
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
#(
   parameter logic [31:0] VECTOR_ADDR     = 32'h0000_0000,
   parameter int          DRAIN_CYCLES    = 3,
   parameter int          RTI_WAIT_CYCLES = 2,
   parameter int          CW              = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   interrupt_sequencer_if.master seq_bus
);

   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LOAD  = CW'(RTI_WAIT_CYCLES - 1);

   seq_state_t    state;
   seq_state_t    state_next;
   logic          pending;
   logic          pending_late;
   logic [31:0]   saved_pc;
   logic          capture_pc;
   logic          cnt_load;
   logic [CW-1:0] cnt_load_value;
   logic          cnt_dec;
   logic          cnt_zero;
   logic          late_window;
   stack_ctl_t    ctl;

   seq_down_counter #(.CW(CW)) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (cnt_load),
      .load_value (cnt_load_value),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   // ---------------- state register and pending tracking ----------------
   // A request arriving after the current interrupt has been committed to
   // (DRAIN..PUSH_FLAGS) is already "covered" by pending, so the VECTOR clear
   // would swallow it. pending_late remembers it and re-arms pending in
   // VECTOR, so a second interrupt gets its own full sequence.
   assign late_window = (state == ST_DRAIN) || (state == ST_PUSH_PC) ||
                        (state == ST_PUSH_FLAGS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pending      <= 1'b0;
         pending_late <= 1'b0;
         saved_pc     <= '0;
      end else begin
         state <= state_next;
         if (state == ST_VECTOR) begin
            // Set wins over clear in the same cycle.
            pending      <= seq_bus.INT_Request | pending_late;
            pending_late <= 1'b0;
         end else begin
            pending      <= seq_bus.INT_Request | pending;
            pending_late <= pending_late | (seq_bus.INT_Request & late_window);
         end
         if (capture_pc) begin
            saved_pc <= seq_bus.Current_PC;
         end
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next     = state;
      capture_pc     = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_value = '0;
      cnt_dec        = 1'b0;
      case (state)
         ST_IDLE: begin
            // RTI first: decode already holds it and must not be overtaken.
            if (seq_bus.RTI_Decoded) begin
               state_next = ST_POP_FLAGS;
            end else if (pending && !seq_bus.Jump_In_Flight) begin
               state_next     = ST_DRAIN;
               capture_pc     = 1'b1;
               cnt_load       = 1'b1;
               cnt_load_value = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (cnt_zero) state_next = ST_PUSH_PC;
            else          cnt_dec    = 1'b1;
         end
         ST_PUSH_PC:    state_next = ST_PUSH_FLAGS;
         ST_PUSH_FLAGS: state_next = ST_VECTOR;
         ST_VECTOR:     state_next = ST_IDLE;
         ST_POP_FLAGS:  state_next = ST_POP_PC;
         ST_POP_PC: begin
            state_next     = ST_RTI_WAIT;
            cnt_load       = 1'b1;
            cnt_load_value = WAIT_LOAD;
         end
         ST_RTI_WAIT: begin
            if (cnt_zero) state_next = ST_IDLE;
            else          cnt_dec    = 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- Moore outputs ----------------
   assign ctl = stack_ctl(state);

   assign seq_bus.Inject_SP          = ctl[CTL_SP];
   assign seq_bus.Inject_SPOP        = ctl[CTL_SPOP];
   assign seq_bus.Inject_MR          = ctl[CTL_MR];
   assign seq_bus.Inject_MW          = ctl[CTL_MW];
   assign seq_bus.Inject_Stack_PC    = ctl[CTL_STACK_PC];
   assign seq_bus.Inject_Stack_Flags = ctl[CTL_STACK_FLAGS];

   assign seq_bus.Inject_Valid  = (state == ST_PUSH_PC)   || (state == ST_PUSH_FLAGS) ||
                                  (state == ST_POP_FLAGS) || (state == ST_POP_PC);
   assign seq_bus.Stall_Fetch   = (state != ST_IDLE) && (state != ST_VECTOR);
   assign seq_bus.Flush_Decode  = (state == ST_DRAIN) || (state == ST_POP_FLAGS);
   assign seq_bus.Inject_PC     = (state == ST_PUSH_PC) ? saved_pc : 32'h0;
   assign seq_bus.PC_Load       = (state == ST_VECTOR);
   assign seq_bus.PC_Load_Value = (state == ST_VECTOR) ? VECTOR_ADDR : 32'h0;
   assign seq_bus.Busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: per-cycle expected outputs from a
// vector table flow through a scoreboard queue, plus an async-reset sequence.
module tb_interrupt_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   interrupt_sequencer_if seq_bus();

   interrupt_sequencer #(
      .VECTOR_ADDR     (32'h0000_0000),
      .DRAIN_CYCLES    (3),
      .RTI_WAIT_CYCLES (2),
      .CW              (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seq_bus (seq_bus)
   );

   typedef struct packed {
      logic        stall;
      logic        flush;
      logic        valid;
      logic        sp;
      logic        spop;
      logic        mr;
      logic        mw;
      logic        spc;
      logic        sflags;
      logic [31:0] inj_pc;
      logic        pc_load;
      logic [31:0] pc_val;
      logic        busy;
   } exp_t;

   typedef struct {
      string       name;
      logic        int_req;
      logic        rti;
      logic        jump;
      logic [31:0] pc;
      exp_t        exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // ---------------- expected output per phase ----------------
   function automatic exp_t e_idle();
      exp_t e = '0;
      return e;
   endfunction
   function automatic exp_t e_drain();
      exp_t e = '0;
      e.stall = 1; e.flush = 1; e.busy = 1;
      return e;
   endfunction
   function automatic exp_t e_push_pc(logic [31:0] pc);
      exp_t e = '0;
      e.stall = 1; e.valid = 1; e.sp = 1; e.mw = 1; e.spc = 1; e.inj_pc = pc; e.busy = 1;
      return e;
   endfunction
   function automatic exp_t e_push_flags();
      exp_t e = '0;
      e.stall = 1; e.valid = 1; e.sp = 1; e.mw = 1; e.sflags = 1; e.busy = 1;
      return e;
   endfunction
   function automatic exp_t e_vector();
      exp_t e = '0;
      e.pc_load = 1; e.pc_val = 32'h0000_0000; e.busy = 1;
      return e;
   endfunction
   function automatic exp_t e_pop_flags();
      exp_t e = '0;
      e.stall = 1; e.flush = 1; e.valid = 1; e.sp = 1; e.spop = 1; e.mr = 1; e.sflags = 1; e.busy = 1;
      return e;
   endfunction
   function automatic exp_t e_pop_pc();
      exp_t e = '0;
      e.stall = 1; e.valid = 1; e.sp = 1; e.spop = 1; e.mr = 1; e.spc = 1; e.busy = 1;
      return e;
   endfunction
   function automatic exp_t e_rti_wait();
      exp_t e = '0;
      e.stall = 1; e.busy = 1;
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t s;
      s.stall   = seq_bus.Stall_Fetch;
      s.flush   = seq_bus.Flush_Decode;
      s.valid   = seq_bus.Inject_Valid;
      s.sp      = seq_bus.Inject_SP;
      s.spop    = seq_bus.Inject_SPOP;
      s.mr      = seq_bus.Inject_MR;
      s.mw      = seq_bus.Inject_MW;
      s.spc     = seq_bus.Inject_Stack_PC;
      s.sflags  = seq_bus.Inject_Stack_Flags;
      s.inj_pc  = seq_bus.Inject_PC;
      s.pc_load = seq_bus.PC_Load;
      s.pc_val  = seq_bus.PC_Load_Value;
      s.busy    = seq_bus.Busy;
      return s;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic check_invariants(input string name, input exp_t act);
      tests++;
      if (act.mr && act.mw) begin
         fails++;
         $display("FAIL %s_mr_mw: got mr=%b mw=%b required not both 1", name, act.mr, act.mw);
      end
      tests++;
      if (act.valid && !act.sp) begin
         fails++;
         $display("FAIL %s_sp_valid: got valid=%b sp=%b required sp=1", name, act.valid, act.sp);
      end
   endtask

   task automatic add(input string n, input logic i, input logic r, input logic j,
                      input logic [31:0] pc, input exp_t e);
      vec_t v;
      v.name = n; v.int_req = i; v.rti = r; v.jump = j; v.pc = pc; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic i, input logic r, input logic j, input logic [31:0] pc);
      seq_bus.INT_Request    = i;
      seq_bus.RTI_Decoded    = r;
      seq_bus.Jump_In_Flight = j;
      seq_bus.Current_PC     = pc;
   endtask

   initial begin
      exp_t got;
      exp_t req;

      // ---------- vector table: inputs held across one edge, outputs after it ----------
      // Basic interrupt entry; RTI during DRAIN must be ignored.
      add("int_pulse",      1, 0, 0, 32'h40, e_idle());
      add("drain1",         0, 0, 0, 32'h40, e_drain());
      add("drain2_rti_ign", 0, 1, 0, 32'h44, e_drain());
      add("drain3",         0, 0, 0, 32'h48, e_drain());
      add("push_pc",        0, 0, 0, 32'h4c, e_push_pc(32'h40));
      add("push_flags",     0, 0, 0, 32'h50, e_push_flags());
      add("vector",         0, 0, 0, 32'h54, e_vector());
      add("idle1",          0, 0, 0, 32'h00, e_idle());
      // RTI
      add("rti_pop_flags",  0, 1, 0, 32'h00, e_pop_flags());
      add("rti_pop_pc",     0, 0, 0, 32'h00, e_pop_pc());
      add("rti_wait1",      0, 0, 0, 32'h00, e_rti_wait());
      add("rti_wait2",      0, 0, 0, 32'h00, e_rti_wait());
      add("rti_done",       0, 0, 0, 32'h00, e_idle());
      add("idle2",          0, 0, 0, 32'h00, e_idle());
      // INT and RTI together: RTI first, interrupt right after with later PC
      add("both_pop_flags", 1, 1, 0, 32'h100, e_pop_flags());
      add("both_pop_pc",    0, 0, 0, 32'h104, e_pop_pc());
      add("both_wait1",     0, 0, 0, 32'h108, e_rti_wait());
      add("both_wait2",     0, 0, 0, 32'h10c, e_rti_wait());
      add("both_idle",      0, 0, 0, 32'h150, e_idle());
      add("both_entry",     0, 0, 0, 32'h200, e_drain());
      add("both_drain2",    0, 0, 0, 32'h300, e_drain());
      add("both_drain3",    0, 0, 0, 32'h300, e_drain());
      add("both_push_pc",   0, 0, 0, 32'h300, e_push_pc(32'h200));
      add("both_push_fl",   0, 0, 0, 32'h300, e_push_flags());
      add("both_vector",    0, 0, 0, 32'h300, e_vector());
      add("both_idle_end",  0, 0, 0, 32'h300, e_idle());
      // Jump in flight delays entry; saved PC is the post-jump one
      add("jmp_int",        1, 0, 1, 32'h80, e_idle());
      add("jmp_hold1",      0, 0, 1, 32'h84, e_idle());
      add("jmp_hold2",      0, 0, 1, 32'h86, e_idle());
      add("jmp_entry",      0, 0, 0, 32'h88, e_drain());
      add("jmp_drain2",     0, 0, 0, 32'h8c, e_drain());
      add("jmp_drain3",     0, 0, 0, 32'h8c, e_drain());
      add("jmp_push_pc",    0, 0, 0, 32'h8c, e_push_pc(32'h88));
      add("jmp_push_fl",    0, 0, 0, 32'h8c, e_push_flags());
      add("jmp_vector",     0, 0, 0, 32'h8c, e_vector());
      add("jmp_idle",       0, 0, 0, 32'h8c, e_idle());
      // Second INT while in PUSH_FLAGS: two complete sequences
      add("dbl_int_a",      1, 0, 0, 32'ha0, e_idle());
      add("dbl_entry_a",    0, 0, 0, 32'ha0, e_drain());
      add("dbl_drain_a2",   0, 0, 0, 32'ha4, e_drain());
      add("dbl_drain_a3",   0, 0, 0, 32'ha4, e_drain());
      add("dbl_push_pc_a",  0, 0, 0, 32'ha4, e_push_pc(32'ha0));
      add("dbl_push_fl_a",  0, 0, 0, 32'ha4, e_push_flags());
      add("dbl_int_b_vec",  1, 0, 0, 32'ha4, e_vector());
      add("dbl_idle_mid",   0, 0, 0, 32'hb0, e_idle());
      add("dbl_entry_b",    0, 0, 0, 32'hc0, e_drain());
      add("dbl_drain_b2",   0, 0, 0, 32'hc4, e_drain());
      add("dbl_drain_b3",   0, 0, 0, 32'hc4, e_drain());
      add("dbl_push_pc_b",  0, 0, 0, 32'hc4, e_push_pc(32'hc0));
      add("dbl_push_fl_b",  0, 0, 0, 32'hc4, e_push_flags());
      add("dbl_vector_b",   0, 0, 0, 32'hc4, e_vector());
      add("dbl_idle_end1",  0, 0, 0, 32'hc4, e_idle());
      add("dbl_idle_end2",  0, 0, 0, 32'hc4, e_idle());

      // ---------- reset state ----------
      drive(0, 0, 0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", sample(), e_idle());
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("after_release", sample(), e_idle());

      // ---------- table through the scoreboard ----------
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].int_req, vecs[i].rti, vecs[i].jump, vecs[i].pc);
         sb.push_back(vecs[i].exp);
         @(posedge clk);
         #1;
         got = sample();
         req = sb.pop_front();
         check(vecs[i].name, got, req);
         check_invariants(vecs[i].name, got);
      end

      // ---------- async reset in the middle of DRAIN ----------
      drive(1, 0, 0, 32'h400);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 32'h400);
      @(posedge clk);
      #1;
      check("pre_reset_drain", sample(), e_drain());
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", sample(), e_idle());
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_reset_idle%0d", k), sample(), e_idle());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Multi-cycle controller that sequences the execute stage's stack datapath for hardware interrupts and RTI. On an interrupt it drains the pipeline, injects a push of the return PC and a push of the flags into the ID/EX stream, then redirects fetch to the interrupt vector. On RTI it injects a pop of the flags and a pop of the PC, then holds fetch until the popped PC reaches the PC register. It sits beside decode and drives the same control fields the ID/EX buffer carries (SP, SPOP, MR, MW, Stack_PC, Stack_Flags).

Parameters:
VECTOR_ADDR, 32'h0000_0000, PC loaded on interrupt entry
DRAIN_CYCLES, 3, stall cycles before the first push so in-flight instructions retire
RTI_WAIT_CYCLES, 2, stall cycles after the PC pop until the memory-stage PC write lands
CW, 3, width of the drain/wait counter; must hold max(DRAIN_CYCLES, RTI_WAIT_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
INT_Request  in  1  interrupt pulse or level; latched into pending
RTI_Decoded  in  1  one-cycle pulse: decode has an RTI
Jump_In_Flight  in  1  Taken_Jump from execute; delays interrupt entry one cycle
Current_PC  in  32  PC of the next unfetched instruction
Stall_Fetch  out  1  freeze PC and IF/ID buffer
Flush_Decode  out  1  insert a bubble in place of the decoded instruction
Inject_Valid  out  1  ID/EX takes the Inject_* fields instead of decode
Inject_SP  out  1  stack operation
Inject_SPOP  out  1  1 = pop (SP+1), 0 = push (SP-1)
Inject_MR  out  1  memory read
Inject_MW  out  1  memory write
Inject_Stack_PC  out  1  stack operand is the PC
Inject_Stack_Flags  out  1  stack operand is the flags
Inject_PC  out  32  return PC to push
PC_Load  out  1  one-cycle PC overwrite strobe
PC_Load_Value  out  32  value for PC_Load
Busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pending=0, counter=0, Saved_PC=0; every output 0.
- pending is set on any clk with INT_Request=1. It is cleared only in VECTOR, and setting wins over clearing in the same cycle.
- States: IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR, POP_FLAGS, POP_PC, RTI_WAIT.
- IDLE: all outputs 0.
  - If RTI_Decoded=1, go to POP_FLAGS. RTI has priority over a pending interrupt.
  - Else if pending=1 and Jump_In_Flight=0: go to DRAIN, capture Saved_PC<=Current_PC, load counter<=DRAIN_CYCLES-1.
  - If pending=1 and Jump_In_Flight=1, remain in IDLE.
- DRAIN: Stall_Fetch=1, Flush_Decode=1. Decrement the counter; at 0, go to PUSH_PC.
- PUSH_PC (1 cycle): Stall_Fetch=1, Inject_Valid=1, Inject_SP=1, Inject_SPOP=0, Inject_MW=1, Inject_Stack_PC=1, Inject_PC=Saved_PC. Go to PUSH_FLAGS.
- PUSH_FLAGS (1 cycle): Stall_Fetch=1, Inject_Valid=1, Inject_SP=1, Inject_MW=1, Inject_Stack_Flags=1. Go to VECTOR.
- VECTOR (1 cycle): PC_Load=1, PC_Load_Value=VECTOR_ADDR, clear pending. Go to IDLE.
- POP_FLAGS (1 cycle): Stall_Fetch=1, Flush_Decode=1, Inject_Valid=1, Inject_SP=1, Inject_SPOP=1, Inject_MR=1, Inject_Stack_Flags=1. Go to POP_PC.
- POP_PC (1 cycle): Stall_Fetch=1, Inject_Valid=1, Inject_SP=1, Inject_SPOP=1, Inject_MR=1, Inject_Stack_PC=1. Load counter<=RTI_WAIT_CYCLES-1 and go to RTI_WAIT.
- RTI_WAIT: Stall_Fetch=1. Decrement the counter; at 0, go to IDLE. The PC itself is written by the memory stage.
- Fixed sequence lengths:
  - Interrupt: 1 IDLE-decision edge + DRAIN_CYCLES + 3 cycles; PC_Load is asserted in cycle DRAIN_CYCLES+3 after the entry edge.
  - RTI: 2 + RTI_WAIT_CYCLES cycles.
- Boundary conditions:
  - INT during any non-IDLE state only sets pending. It is served after the sequence returns to IDLE, so it is never lost and never nested mid-sequence.
  - RTI_Decoded outside IDLE is ignored, because decode is stalled there.
  - Inject_* outputs are mutually consistent: Inject_MR and Inject_MW are never both 1, and Inject_SP=1 whenever Inject_Valid=1.
  - Inject_PC is driven only in PUSH_PC and is 0 otherwise.
  - rst_n low mid-sequence aborts to IDLE immediately, with pending=0.
- All outputs are decoded from registered state (Moore). There is no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (3-bit) and the stack-control field bit positions that match the ID/EX buffer layout.
- One sub-module, seq_down_counter: a loadable CW-bit down-counter with a zero flag, shared by DRAIN and RTI_WAIT.

Test Plan:
- Reset with rst_n=0 mid-DRAIN -> all outputs 0 asynchronously; Busy=0 after release.
- INT_Request pulse, Current_PC=32'h0000_0040, DRAIN_CYCLES=3 -> Stall_Fetch high 5 cycles; PUSH_PC with Inject_PC=32'h40, Inject_MW=1, Inject_SPOP=0; next cycle Stack_Flags push; then PC_Load=1 with PC_Load_Value=32'h0.
- RTI_Decoded pulse -> POP_FLAGS (SPOP=1, MR=1, Stack_Flags=1), then POP_PC (Stack_PC=1), Stall_Fetch held 4 cycles, Busy drops after.
- INT_Request and RTI_Decoded in the same IDLE cycle -> RTI sequence runs first; the interrupt sequence starts on the first IDLE cycle after it, with Saved_PC sampled then.
- INT_Request while Jump_In_Flight=1 for 2 cycles -> stays IDLE for those 2 cycles, then enters DRAIN; Saved_PC equals the post-jump Current_PC.
- Second INT_Request during PUSH_FLAGS -> first sequence completes; a second full sequence follows immediately, with exactly two PC_Load pulses in total.
